// File: rtl/winograd_tile_buffer.sv
// Four-row line buffer that turns a raster pixel stream into stride-2 4x4 tiles for a Winograd F(2x2,3x3) input transform.
// Optional macro WINOGRAD_TILE_BUFFER_CNT_EN adds a free-running 32-bit tile_count output.
module winograd_tile_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic signed [DATA_WIDTH-1:0] tile [16],
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
    output logic [31:0]                  tile_count,
`endif
    output logic                         out_last
);

    localparam int unsigned NTX   = (IMG_WIDTH - 2) / 2;
    localparam int unsigned NTY   = (IMG_HEIGHT - 2) / 2;
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned TX_W  = $clog2(NTX + 1);
    localparam int unsigned TY_W  = $clog2(NTY + 1);

    // Geometry must allow at least one tile; the Q format must keep an integer part.
    if (IMG_WIDTH < 4 || (IMG_WIDTH % 2) != 0 || IMG_HEIGHT < 4 || (IMG_HEIGHT % 2) != 0 ||
        FRAC_WIDTH >= DATA_WIDTH) begin : g_param_check
        $error("winograd_tile_buffer: invalid parameters");
    end

    typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_e;

    state_e                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  buf_q [4][IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0]  buf_d [4][IMG_WIDTH];
    logic [1:0]                    base_q, base_d;
    logic [2:0]                    row_q, row_d;
    logic [COL_W-1:0]              col_q, col_d;
    logic [TX_W-1:0]               tx_q, tx_d;
    logic [TY_W-1:0]               ty_q, ty_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;
    logic                          out_last_q, out_last_d;
    logic signed [DATA_WIDTH-1:0]  tile_q [16];
    logic signed [DATA_WIDTH-1:0]  tile_d [16];
    logic [1:0]                    wr_row;
    logic [2:0]                    need_rows;
    logic [COL_W-1:0]              col0;
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
    logic [31:0]                   tile_count_q, tile_count_d;
`endif

    // Next-state, buffer write and registered-output computation.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        base_d      = base_q;
        row_d       = row_q;
        col_d       = col_q;
        tx_d        = tx_q;
        ty_d        = ty_q;
        tile_d      = tile_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        col0        = '0;
        // The first group of a frame fills all four rows; later groups refill the two rows just retired.
        need_rows   = (ty_q == '0) ? 3'd4 : 3'd2;
        wr_row      = base_q + 2'(row_q) + ((ty_q == '0) ? 2'd0 : 2'd2);
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
        tile_count_d = tile_count_q;
`endif

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    buf_d[wr_row][col_q] = in_data;
                    if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                        col_d = '0;
                        if (row_q + 3'd1 == need_rows) begin
                            row_d   = '0;
                            state_d = EMIT;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
                    tile_count_d = tile_count_q + 32'd1;
`endif
                    if (tx_q == TX_W'(NTX - 1)) begin
                        tx_d    = '0;
                        state_d = FILL;
                        if (ty_q == TY_W'(NTY - 1)) begin
                            ty_d   = '0;
                            base_d = '0;
                            row_d  = '0;
                        end else begin
                            ty_d   = ty_q + TY_W'(1);
                            base_d = base_q + 2'd2;
                        end
                    end else begin
                        tx_d = tx_q + TX_W'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == EMIT);
        out_last_d  = out_valid_d && (tx_d == TX_W'(NTX - 1)) && (ty_d == TY_W'(NTY - 1));

        // Tile is latched from the post-write buffer so it is valid the cycle EMIT begins.
        if (state_d == EMIT) begin
            col0 = COL_W'(tx_d) << 1;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    tile_d[r*4 + c] = buf_d[2'(base_d + 2'(r))][col0 + COL_W'(c)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            base_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < int'(IMG_WIDTH); c++) begin
                    buf_q[r][c] <= '0;
                end
            end
            for (int k = 0; k < 16; k++) begin
                tile_q[k] <= '0;
            end
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
            tile_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            buf_q       <= buf_d;
            tile_q      <= tile_d;
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
            tile_count_q <= tile_count_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign tile      = tile_q;
`ifdef WINOGRAD_TILE_BUFFER_CNT_EN
    assign tile_count = tile_count_q;
`endif

endmodule

// File: doc/winograd_tile_buffer.md
WINOGRAD_TILE_BUFFER -- requirements
Module: winograd_tile_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning pixel width in bits (Q8.8 signed).
REQ-002 SHALL have parameter FRAC_WIDTH, default 8, meaning fractional bits; the data path passes it through unchanged.
REQ-003 SHALL have parameter IMG_WIDTH, default 32, meaning feature-map columns (even, >=4).
REQ-004 SHALL have parameter IMG_HEIGHT, default 32, meaning feature-map rows (even, >=4).
REQ-005 SHALL have port clk, input, 1 bit, meaning single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning in_data carries a pixel.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts a pixel this cycle.
REQ-009 SHALL have port in_data, input, signed DATA_WIDTH, meaning pixel in raster order (row-major, row 0 first).
REQ-010 SHALL have port tile, output, signed DATA_WIDTH x 16 unpacked array, meaning 4x4 tile, element r*4+c = row r, column c; it feeds the Winograd F(2x2,3x3) input transform directly.
REQ-011 SHALL have port out_valid, output, 1 bit, meaning tile is valid.
REQ-012 SHALL have port out_ready, input, 1 bit, meaning downstream accepts tile.
REQ-013 SHALL have port out_last, output, 1 bit, meaning the current tile is the last of the frame.

Function
REQ-014 SHALL store four image rows in a register array of 4 x IMG_WIDTH entries, addressed by a 2-bit circular row base pointer.
REQ-015 SHALL produce tiles at stride 2: tile (ty,tx) covers rows 2ty..2ty+3 and columns 2tx..2tx+3, with no padding.
REQ-016 SHALL emit NTX=(IMG_WIDTH-2)/2 tiles per row group and NTY=(IMG_HEIGHT-2)/2 row groups per frame, in order tx ascending within ty ascending.
REQ-017 SHALL implement states FILL and EMIT; in_ready=1 only in FILL; out_valid=1 only in EMIT.
REQ-018 In FILL, a pixel SHALL be written when in_valid&&in_ready, advancing a column counter that wraps at IMG_WIDTH-1 and increments a row counter.
REQ-019 FILL SHALL need 4 rows for the first group of a frame and 2 rows for each later group; the last required pixel is written in cycle N, the state is EMIT in cycle N+1 with out_valid=1.
REQ-020 In EMIT, tile SHALL read physical row (base+r) mod 4, columns 2tx..2tx+3, and stay stable while out_valid&&!out_ready.
REQ-021 On out_valid&&out_ready, tx SHALL increment; the next tile is presented in the next cycle with no bubble.
REQ-022 On acceptance of tile tx=NTX-1: if ty<NTY-1, base advances by 2 mod 4, ty increments, and the state returns to FILL, which writes the next two rows into physical rows (base+2) and (base+3); otherwise ty, base and the row counter clear and the state returns to FILL for a new 4-row frame.
REQ-023 out_last SHALL be 1 exactly when out_valid, tx=NTX-1 and ty=NTY-1.
REQ-024 in_valid SHALL be ignored while in_ready=0; no pixel is lost or duplicated across FILL/EMIT boundaries.
REQ-025 For IMG_WIDTH=IMG_HEIGHT=4 the block SHALL emit exactly one tile per frame, with out_last=1.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously enter FILL; clear base, row, column, tx and ty counters and all buffer entries to 0; and drive out_valid=0, out_last=0, all tile elements 0 and in_ready=1 after release.
REQ-027 Reset asserted mid-frame or mid-EMIT SHALL discard the partial frame; the first pixel after release is row 0, column 0.

Configuration
REQ-028 With macro WINOGRAD_TILE_BUFFER_CNT_EN defined, the block SHALL add output port tile_count (32-bit), reset to 0, incremented on each tile handshake, wrapping at 2^32-1 and never cleared at frame end.
REQ-029 Without WINOGRAD_TILE_BUFFER_CNT_EN, port tile_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 4x4 frame with pixels 1..16 in raster order and out_ready=1 -> one tile equal to 1..16 in order, with out_last=1 and out_valid high one cycle after pixel 16.
REQ-031 6x6 frame, pixel = row*6+col -> 4 tiles; tile(0,1)[0]=2, tile(1,0)[0]=12, tile(1,1)[0]=14, tile(1,1)[15]=35; out_last only on the fourth tile.
REQ-032 6x6 frame with out_ready held 0 for 5 cycles on the first tile -> tile and out_valid stable, in_ready=0 throughout, and the sequence matches REQ-031 afterwards.
REQ-033 in_valid toggling randomly at 50% over two back-to-back 8x8 frames -> 9 tiles per frame, bit-exact against a software stride-2 tiler.
REQ-034 rst_n pulsed low during EMIT of tile 2 of a 6x6 frame -> out_valid=0 immediately; a following full frame yields the correct 4 tiles.
REQ-035 With WINOGRAD_TILE_BUFFER_CNT_EN defined, two 6x6 frames -> tile_count=8 at the end; without it, the port is absent and the build is clean.
